// File: rtl/tcp_tx_stream_fifo.sv
// TX payload FIFO between the BRAM read engine and the packet builder.
// First-word-fall-through AXI4-Stream output with optional store-and-forward gating.
module tcp_tx_stream_fifo #(
    parameter int DATA_BITS = 512,
    parameter int DEPTH     = 1024,
    parameter int AF_THRESH = DEPTH - 8,
    parameter int PKT_MODE  = 0,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 wr_en_i,
    input  logic [DATA_BITS-1:0] wr_data_i,
    input  logic                 wr_last_i,
    output logic                 full_o,
    output logic                 almost_full_o,
    output logic                 overflow_o,
    output logic [DATA_BITS-1:0] m_axis_tdata_o,
    output logic                 m_axis_tlast_o,
    output logic                 m_axis_tvalid_o,
    input  logic                 m_axis_tready_i,
    output logic [AW:0]          count_o,
    output logic [AW:0]          pkt_count_o
);

    localparam int CW = AW + 1;

    logic [DATA_BITS:0]   mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        arr_cnt_q, arr_cnt_d;
    logic [CW-1:0]        count_q, count_d;
    logic [CW-1:0]        pkt_q, pkt_d;
    logic [DATA_BITS-1:0] tdata_q, tdata_d;
    logic                 tlast_q, tlast_d;
    logic                 out_vld_q, out_vld_d;
    logic                 tvalid_q, tvalid_d;
    logic                 full_q, full_d;
    logic                 af_q, af_d;
    logic                 ovf_q, ovf_d;
    logic                 wr_acc_s, xfer_s, arr_push_s, arr_pop_s;

    // Next-state: output-register refill/bypass, array push/pop and occupancy counters.
    always_comb begin
        wr_acc_s   = wr_en_i && !full_q;
        xfer_s     = tvalid_q && m_axis_tready_i;
        arr_push_s = 1'b0;
        arr_pop_s  = 1'b0;
        out_vld_d  = out_vld_q;
        tdata_d    = tdata_q;
        tlast_d    = tlast_q;

        // out_vld_q can be set while tvalid is gated off in store-and-forward mode.
        if (!out_vld_q || xfer_s) begin
            if (arr_cnt_q != '0) begin
                out_vld_d            = 1'b1;
                {tlast_d, tdata_d}   = mem_q[rd_ptr_q];
                arr_pop_s            = 1'b1;
                arr_push_s           = wr_acc_s;
            end else if (wr_acc_s) begin
                out_vld_d = 1'b1;
                tdata_d   = wr_data_i;
                tlast_d   = wr_last_i;
            end else begin
                out_vld_d = 1'b0;
            end
        end else begin
            arr_push_s = wr_acc_s;
        end

        wr_ptr_d = arr_push_s ? (wr_ptr_q + AW'(1'b1)) : wr_ptr_q;
        rd_ptr_d = arr_pop_s  ? (rd_ptr_q + AW'(1'b1)) : rd_ptr_q;

        case ({arr_push_s, arr_pop_s})
            2'b10:   arr_cnt_d = arr_cnt_q + CW'(1'b1);
            2'b01:   arr_cnt_d = arr_cnt_q - CW'(1'b1);
            default: arr_cnt_d = arr_cnt_q;
        endcase

        case ({wr_acc_s, xfer_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase

        case ({wr_acc_s && wr_last_i, xfer_s && tlast_q})
            2'b10:   pkt_d = pkt_q + CW'(1'b1);
            2'b01:   pkt_d = pkt_q - CW'(1'b1);
            default: pkt_d = pkt_q;
        endcase

        ovf_d    = ovf_q || (wr_en_i && full_q);
        full_d   = (count_d == CW'(DEPTH));
        af_d     = (count_d >= CW'(AF_THRESH));
        tvalid_d = out_vld_d && ((PKT_MODE == 0) || (pkt_d != '0));
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            arr_cnt_q <= '0;
            count_q   <= '0;
            pkt_q     <= '0;
            tdata_q   <= '0;
            tlast_q   <= 1'b0;
            out_vld_q <= 1'b0;
            tvalid_q  <= 1'b0;
            full_q    <= 1'b0;
            af_q      <= (AF_THRESH == 0);
            ovf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            arr_cnt_q <= arr_cnt_d;
            count_q   <= count_d;
            pkt_q     <= pkt_d;
            tdata_q   <= tdata_d;
            tlast_q   <= tlast_d;
            out_vld_q <= out_vld_d;
            tvalid_q  <= tvalid_d;
            full_q    <= full_d;
            af_q      <= af_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage array; deliberately not cleared on reset.
    always_ff @(posedge clk) begin
        if (resetn && arr_push_s) begin
            mem_q[wr_ptr_q] <= {wr_last_i, wr_data_i};
        end
    end

    assign full_o          = full_q;
    assign almost_full_o   = af_q;
    assign overflow_o      = ovf_q;
    assign m_axis_tdata_o  = tdata_q;
    assign m_axis_tlast_o  = tlast_q;
    assign m_axis_tvalid_o = tvalid_q;
    assign count_o         = count_q;
    assign pkt_count_o     = pkt_q;

endmodule

// File: tb/tb_tcp_tx_stream_fifo.sv
// Directed bench for tcp_tx_stream_fifo: cut-through instance (DEPTH=64) and
// store-and-forward instance (DEPTH=16), checked against hand-computed values.
module tb_tcp_tx_stream_fifo;

    localparam int DW  = 32;
    localparam int D   = 64;
    localparam int AW  = 6;
    localparam int AFT = 56;
    localparam int DP  = 16;
    localparam int AWP = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    logic          wr_en = 1'b0, wr_last = 1'b0, tready = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          full, af, ovf, tlast, tvalid;
    logic [DW-1:0] tdata;
    logic [AW:0]   count, pkt_count;

    logic           wr_en_p = 1'b0, wr_last_p = 1'b0, tready_p = 1'b0;
    logic [DW-1:0]  wr_data_p = '0;
    logic           full_p, af_p, ovf_p, tlast_p, tvalid_p;
    logic [DW-1:0]  tdata_p;
    logic [AWP:0]   count_p, pkt_count_p;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    tcp_tx_stream_fifo #(.DATA_BITS(DW), .DEPTH(D), .AF_THRESH(AFT), .PKT_MODE(0)) dut (
        .clk(clk), .resetn(resetn),
        .wr_en_i(wr_en), .wr_data_i(wr_data), .wr_last_i(wr_last),
        .full_o(full), .almost_full_o(af), .overflow_o(ovf),
        .m_axis_tdata_o(tdata), .m_axis_tlast_o(tlast), .m_axis_tvalid_o(tvalid),
        .m_axis_tready_i(tready), .count_o(count), .pkt_count_o(pkt_count)
    );

    tcp_tx_stream_fifo #(.DATA_BITS(DW), .DEPTH(DP), .PKT_MODE(1)) dut_p (
        .clk(clk), .resetn(resetn),
        .wr_en_i(wr_en_p), .wr_data_i(wr_data_p), .wr_last_i(wr_last_p),
        .full_o(full_p), .almost_full_o(af_p), .overflow_o(ovf_p),
        .m_axis_tdata_o(tdata_p), .m_axis_tlast_o(tlast_p), .m_axis_tvalid_o(tvalid_p),
        .m_axis_tready_i(tready_p), .count_o(count_p), .pkt_count_o(pkt_count_p)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        checks++; if (count !== 7'd0) $display("FAIL reset_count: got %0d want 0", count); else passed++;
        checks++; if (pkt_count !== 7'd0) $display("FAIL reset_pkt: got %0d want 0", pkt_count); else passed++;
        checks++; if (tvalid !== 1'b0) $display("FAIL reset_tvalid: got %0b want 0", tvalid); else passed++;
        checks++; if (tlast !== 1'b0) $display("FAIL reset_tlast: got %0b want 0", tlast); else passed++;
        checks++; if (full !== 1'b0) $display("FAIL reset_full: got %0b want 0", full); else passed++;
        checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %0b want 0", ovf); else passed++;
        checks++; if (af !== 1'b0) $display("FAIL reset_af: got %0b want 0", af); else passed++;
        checks++; if (tdata !== 32'd0) $display("FAIL reset_tdata: got %0h want 0", tdata); else passed++;
        checks++; if (tvalid_p !== 1'b0) $display("FAIL reset_tvalid_p: got %0b want 0", tvalid_p); else passed++;
        checks++; if (count_p !== 5'd0) $display("FAIL reset_count_p: got %0d want 0", count_p); else passed++;
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        tready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            wr_en = 1'b1; wr_data = DW'(i); wr_last = (i == 4);
            tick();
            checks++; if (tvalid !== 1'b1) $display("FAIL basic_tvalid[%0d]: got %0b want 1", i, tvalid); else passed++;
            checks++; if (tdata !== DW'(i)) $display("FAIL basic_tdata[%0d]: got %0h want %0h", i, tdata, i); else passed++;
            checks++; if (tlast !== (i == 4)) $display("FAIL basic_tlast[%0d]: got %0b want %0b", i, tlast, (i == 4)); else passed++;
            checks++; if (count !== 7'd1) $display("FAIL basic_count[%0d]: got %0d want 1", i, count); else passed++;
        end
        checks++; if (pkt_count !== 7'd1) $display("FAIL basic_pkt: got %0d want 1", pkt_count); else passed++;
        wr_en = 1'b0; wr_last = 1'b0;
        tick();
        checks++; if (tvalid !== 1'b0) $display("FAIL basic_end_tvalid: got %0b want 0", tvalid); else passed++;
        checks++; if (count !== 7'd0) $display("FAIL basic_end_count: got %0d want 0", count); else passed++;
        checks++; if (pkt_count !== 7'd0) $display("FAIL basic_end_pkt: got %0d want 0", pkt_count); else passed++;
    endtask

    task automatic test_fill_drain();
        tready = 1'b0; wr_last = 1'b0;
        for (int i = 0; i < D; i++) begin
            wr_en = 1'b1; wr_data = DW'(100 + i);
            tick();
            checks++; if (count !== 7'(i + 1)) $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1); else passed++;
            checks++; if (full !== (i == D - 1)) $display("FAIL fill_full[%0d]: got %0b want %0b", i, full, (i == D - 1)); else passed++;
            checks++; if (af !== (i + 1 >= AFT)) $display("FAIL fill_af[%0d]: got %0b want %0b", i, af, (i + 1 >= AFT)); else passed++;
        end
        wr_data = DW'(999);
        tick();
        checks++; if (ovf !== 1'b1) $display("FAIL overflow_set: got %0b want 1", ovf); else passed++;
        checks++; if (count !== 7'd64) $display("FAIL overflow_count: got %0d want 64", count); else passed++;
        checks++; if (tdata !== DW'(100)) $display("FAIL overflow_head: got %0d want 100", tdata); else passed++;
        tready = 1'b1;
        tick();
        checks++; if (count !== 7'd63) $display("FAIL full_rw_count: got %0d want 63", count); else passed++;
        checks++; if (full !== 1'b0) $display("FAIL full_rw_full: got %0b want 0", full); else passed++;
        wr_en = 1'b0;
        for (int i = 1; i < D; i++) begin
            checks++; if (tvalid !== 1'b1 || tdata !== DW'(100 + i))
                $display("FAIL drain_data[%0d]: got v=%0b d=%0d want v=1 d=%0d", i, tvalid, tdata, 100 + i); else passed++;
            checks++; if (count !== 7'(D - i)) $display("FAIL drain_count[%0d]: got %0d want %0d", i, count, D - i); else passed++;
            checks++; if (af !== (D - i >= AFT)) $display("FAIL drain_af[%0d]: got %0b want %0b", i, af, (D - i >= AFT)); else passed++;
            tick();
        end
        checks++; if (tvalid !== 1'b0 || count !== 7'd0) $display("FAIL drain_end: got v=%0b c=%0d want v=0 c=0", tvalid, count); else passed++;
        checks++; if (ovf !== 1'b1) $display("FAIL overflow_sticky: got %0b want 1", ovf); else passed++;
    endtask

    task automatic test_random_stream();
        logic [DW:0]   q[$];
        int            sent = 0, reads = 0, cycles = 0;
        logic          prev_stall = 1'b0;
        logic [DW-1:0] prev_data = '0;
        logic [DW:0]   head;
        while (reads < 3 * D && cycles < 5000) begin
            checks++; if (tvalid !== (q.size() > 0)) $display("FAIL rnd_tvalid[%0d]: got %0b want %0b", cycles, tvalid, (q.size() > 0)); else passed++;
            checks++; if (count !== 7'(q.size())) $display("FAIL rnd_count[%0d]: got %0d want %0d", cycles, count, q.size()); else passed++;
            checks++; if (full !== (q.size() == D)) $display("FAIL rnd_full[%0d]: got %0b want %0b", cycles, full, (q.size() == D)); else passed++;
            if (q.size() > 0) begin
                head = q[0];
                checks++; if (tdata !== head[DW-1:0] || tlast !== head[DW])
                    $display("FAIL rnd_head[%0d]: got d=%0d l=%0b want d=%0d l=%0b", cycles, tdata, tlast, head[DW-1:0], head[DW]); else passed++;
            end
            if (prev_stall) begin
                checks++; if (tdata !== prev_data) $display("FAIL rnd_stable[%0d]: got %0d want %0d", cycles, tdata, prev_data); else passed++;
            end
            tready  = 1'($urandom_range(0, 1));
            wr_en   = (sent < 3 * D) && (q.size() < D) && ($urandom_range(0, 3) != 0);
            wr_data = DW'(5000 + sent);
            wr_last = (sent % 5 == 4);
            prev_stall = (q.size() > 0) && !tready;
            prev_data  = tdata;
            tick();
            if ((q.size() > 0) && tready) begin
                void'(q.pop_front());
                reads++;
            end
            if (wr_en) begin
                q.push_back({wr_last, wr_data});
                sent++;
            end
            cycles++;
        end
        wr_en = 1'b0; wr_last = 1'b0;
        checks++; if (reads != 3 * D) $display("FAIL rnd_timeout: got %0d reads want %0d", reads, 3 * D); else passed++;
    endtask

    task automatic test_midreset();
        tready = 1'b0; wr_last = 1'b0;
        for (int i = 0; i < 37; i++) begin
            wr_en = 1'b1; wr_data = DW'(200 + i);
            tick();
        end
        checks++; if (count !== 7'd37) $display("FAIL mid_count: got %0d want 37", count); else passed++;
        wr_en = 1'b0; resetn = 1'b0;
        tick();
        checks++; if (count !== 7'd0) $display("FAIL mid_rst_count: got %0d want 0", count); else passed++;
        checks++; if (tvalid !== 1'b0) $display("FAIL mid_rst_tvalid: got %0b want 0", tvalid); else passed++;
        checks++; if (ovf !== 1'b0) $display("FAIL mid_rst_ovf: got %0b want 0", ovf); else passed++;
        checks++; if (tdata !== 32'd0) $display("FAIL mid_rst_tdata: got %0h want 0", tdata); else passed++;
        resetn = 1'b1; wr_en = 1'b1; wr_data = 32'h0000_0ABC; wr_last = 1'b1;
        tick();
        checks++; if (tvalid !== 1'b1 || tdata !== 32'h0000_0ABC || tlast !== 1'b1)
            $display("FAIL mid_fresh_head: got v=%0b d=%0h l=%0b want v=1 d=abc l=1", tvalid, tdata, tlast); else passed++;
        checks++; if (count !== 7'd1) $display("FAIL mid_fresh_count: got %0d want 1", count); else passed++;
        wr_en = 1'b0; wr_last = 1'b0; tready = 1'b1;
        tick();
        checks++; if (tvalid !== 1'b0 || count !== 7'd0) $display("FAIL mid_drain: got v=%0b c=%0d want v=0 c=0", tvalid, count); else passed++;
    endtask

    task automatic test_pkt_mode();
        tready_p = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_en_p = 1'b1; wr_data_p = DW'(300 + i); wr_last_p = (i == 5);
            tick();
            checks++; if (tvalid_p !== (i == 5)) $display("FAIL pkt_tvalid[%0d]: got %0b want %0b", i, tvalid_p, (i == 5)); else passed++;
            checks++; if (count_p !== 5'(i + 1)) $display("FAIL pkt_count_words[%0d]: got %0d want %0d", i, count_p, i + 1); else passed++;
            checks++; if (pkt_count_p !== 5'(i == 5)) $display("FAIL pkt_pkts[%0d]: got %0d want %0d", i, pkt_count_p, (i == 5)); else passed++;
        end
        checks++; if (tdata_p !== DW'(300)) $display("FAIL pkt_hold_head: got %0d want 300", tdata_p); else passed++;
        wr_en_p = 1'b0; wr_last_p = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++; if (tvalid_p !== 1'b1 || tdata_p !== DW'(300 + i) || tlast_p !== (i == 5))
                $display("FAIL pkt_drain[%0d]: got v=%0b d=%0d l=%0b want v=1 d=%0d l=%0b", i, tvalid_p, tdata_p, tlast_p, 300 + i, (i == 5)); else passed++;
            tick();
        end
        checks++; if (tvalid_p !== 1'b0) $display("FAIL pkt_end_tvalid: got %0b want 0", tvalid_p); else passed++;
        checks++; if (pkt_count_p !== 5'd0 || count_p !== 5'd0)
            $display("FAIL pkt_end_counts: got p=%0d c=%0d want 0/0", pkt_count_p, count_p); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_drain();
        test_random_stream();
        test_midreset();
        test_pkt_mode();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/tcp_tx_stream_fifo.md
# tcp_tx_stream_fifo

Parametrised TX payload FIFO for the TCP transmit path. It accepts words from the BRAM port-B read engine and presents them as an AXI4-Stream master toward the packet builder. It supports simultaneous read/write, exact occupancy and almost-full reporting, and per-word packet boundaries. An optional store-and-forward mode releases data only once a complete packet (tlast-terminated) is buffered.

## Interface
- DATA_BITS, 512: word width.
- DEPTH, 1024: word capacity; power of two, ≥ 4.
- AF_THRESH, DEPTH-8: almost_full asserts when count ≥ AF_THRESH.
- PKT_MODE, 0: 0 = cut-through; 1 = store-and-forward.
- AW: derived, $clog2(DEPTH); pointer width. Occupancy fields are AW+1 bits.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- resetn  in  1  reset; synchronous, active-low.
- wr_en  in  1  write strobe.
- wr_data  in  DATA_BITS  write word.
- wr_last  in  1  marks the word as the final word of a packet.
- full  out  1  count == DEPTH.
- almost_full  out  1  count ≥ AF_THRESH.
- overflow  out  1  sticky; set by a write attempted while full.
- m_axis_tdata  out  DATA_BITS  head word.
- m_axis_tlast  out  1  last flag of the head word.
- m_axis_tvalid  out  1  head word valid.
- m_axis_tready  in  1  consumer ready.
- count  out  AW+1  words held, including the output register.
- pkt_count  out  AW+1  complete packets held, i.e. wr_last words accepted minus tlast words read.

## Operation
- Storage: DEPTH×(DATA_BITS+1) array (data plus last bit), with AW-bit wr_ptr and rd_ptr that wrap naturally at DEPTH. No memory initialisation on reset.
- Output stage: one output register (tdata, tlast, tvalid), first-word-fall-through.
- Write: accepted when wr_en && !full. A rejected write leaves array, pointers and count unchanged and sets overflow.
- Read: a transfer occurs when m_axis_tvalid && m_axis_tready.
  - After a transfer, the output register reloads from the array if a word is present, else tvalid falls.
- Bypass: a write that arrives while the array is empty and the output register is empty or draining this cycle loads the output register directly.
- Occupancy: count += accepted write, −= transfer; a simultaneous write and transfer leaves count unchanged.
- Packet counter: pkt_count += accepted write with wr_last, −= transfer with tlast.
- PKT_MODE=1 gating: m_axis_tvalid asserts only while pkt_count > 0; the output register holds its data regardless.
  - If DEPTH words arrive with no wr_last, the FIFO stalls full and asserts no tvalid. This is documented behaviour; the upstream must bound packet length to DEPTH.
- Reset (resetn=0 at a clock edge) aborts any in-flight data. Values after reset:
  - pointers, count, pkt_count = 0
  - m_axis_tvalid, m_axis_tlast, full, overflow = 0
  - almost_full = (AF_THRESH == 0)
  - m_axis_tdata = 0

## Timing
- Write-to-valid, empty FIFO, PKT_MODE=0: word accepted at edge N gives tvalid=1 after edge N.
- Write-to-valid, PKT_MODE=1: tvalid=1 after the edge that accepts the wr_last word.
- Throughput: one word per cycle sustained, with wr_en and tready both held high.
- full, almost_full, count and pkt_count are registered. They reflect all transfers up to and including the previous edge.
- full is not lookahead: a write on the cycle after count reaches DEPTH-1 is accepted only if full=0.
- AXI rule: while tvalid=1 and tready=0, tdata and tlast hold stable.
- Simultaneous write and read while full: the write is rejected because full=1, the read completes, and full falls next cycle.
- Simultaneous write and read with count=1: bypass keeps tvalid high continuously.

## Test plan
- Reset, then write 0x1..0x4 (last on 0x4) with tready=1 → tdata 0x1..0x4 on consecutive cycles, tlast only on 0x4, count returns to 0.
- Fill DEPTH words with tready=0 → full=1 at count=DEPTH. The next write sets overflow=1; draining returns all DEPTH words in order with none lost, verifying pointer wrap.
- AF_THRESH=DEPTH-8 → almost_full rises exactly when count becomes DEPTH-8 and falls at DEPTH-9.
- Continuous write and read for 3×DEPTH words with random tready → data order preserved and count bounded; tdata stable during every tvalid && !tready cycle.
- PKT_MODE=1: write 5 words without last → tvalid=0. The 6th word with last → tvalid=1 next cycle and pkt_count=1; after draining, pkt_count=0.
- Assert resetn=0 mid-burst with count=37 → next cycle count=0, tvalid=0, overflow=0; the next write appears as a fresh head word.
